// File: rtl/pipelined_regfile_pkg.sv
// Shared definitions for the pipelined integer register file.
// Width defaults, sequencer state encoding and the hard-wired zero register.
package pipelined_regfile_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int REG_X0     = 0;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } rf_state_e;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the pipelined register file.
// Handles x0 masking, write-to-read forwarding and pending masking.
module regfile_read_port
   import pipelined_regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int BYPASS = 1
) (
   input  logic              i_run,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_rdata,
   input  logic              i_pend,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_data,
   output logic              o_pend
);

   logic w_hit;
   logic w_x0;

   // Select x0 zero, forwarded write data or stored data
   always_comb begin
      w_hit  = (BYPASS != 0) && i_we && (i_waddr == i_addr);
      w_x0   = (i_addr == ADDR_W'(REG_X0));
      o_data = '0;
      o_pend = 1'b0;
      if (i_run && !w_x0) begin
         if (w_hit) begin
            o_data = i_wdata;
         end else begin
            o_data = i_rdata;
            o_pend = i_pend;
         end
      end
   end

endmodule

// File: rtl/pipelined_regfile.sv
// Pipelined integer register file: NREAD read ports, one write port,
// load-pending scoreboard and a one-register-per-cycle clear sequencer.
module pipelined_regfile
   import pipelined_regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NREAD  = 2,
   parameter int BYPASS = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic                    init_done,
   input  logic [NREAD*ADDR_W-1:0] rd_addr,
   output logic [NREAD*DATA_W-1:0] rd_data,
   output logic [NREAD-1:0]        rd_pending,
   input  logic                    we,
   input  logic [ADDR_W-1:0]       waddr,
   input  logic [DATA_W-1:0]       wdata,
   input  logic                    claim_valid,
   input  logic [ADDR_W-1:0]       claim_addr
);

   localparam int DEPTH = 2 ** ADDR_W;

   rf_state_e         r_state;
   rf_state_e         w_state_nxt;
   logic [ADDR_W-1:0] r_clr_idx;
   logic              r_init_done;
   logic [DEPTH-1:0]  r_pend;
   logic [DATA_W-1:0] r_regs [DEPTH];
   logic              w_run;
   logic              w_run_we;
   logic              w_wr_en;
   logic              w_claim_en;

   assign w_run      = (r_state == ST_RUN);
   assign w_run_we   = w_run && we;
   assign w_wr_en    = w_run_we && !rst &&
                       (waddr != ADDR_W'(REG_X0));
   assign w_claim_en = w_run && claim_valid &&
                       (claim_addr != ADDR_W'(REG_X0));
   assign init_done  = r_init_done;

   // Sequencer state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_CLEAR;
      else     r_state <= w_state_nxt;
   end

   // Leave CLEAR once the last register has been zeroed
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_CLEAR:
            if (r_clr_idx == ADDR_W'(DEPTH - 1))
               w_state_nxt = ST_RUN;
         ST_RUN:
            w_state_nxt = ST_RUN;
      endcase
   end

   // Clear index walks every register once per clear sequence
   always_ff @(posedge clk) begin
      if (rst)                    r_clr_idx <= '0;
      else if (r_state == ST_CLEAR) r_clr_idx <= r_clr_idx + 1'b1;
   end

   // init_done tracks the registered RUN state
   always_ff @(posedge clk) begin
      if (rst) r_init_done <= 1'b0;
      else     r_init_done <= (w_state_nxt == ST_RUN);
   end

   // Storage: zeroed by the sequencer, written only in RUN
   always_ff @(posedge clk) begin
      if (r_state == ST_CLEAR) r_regs[r_clr_idx] <= '0;
      else if (w_wr_en)        r_regs[waddr]     <= wdata;
   end

   // Scoreboard: a write releases, a same-cycle claim wins
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend <= '0;
      end else if (w_run) begin
         if (we)         r_pend[waddr]      <= 1'b0;
         if (w_claim_en) r_pend[claim_addr] <= 1'b1;
      end
   end

   for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];

      regfile_read_port #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .BYPASS (BYPASS)
      ) u_port (
         .i_run   (w_run),
         .i_addr  (w_addr),
         .i_rdata (r_regs[w_addr]),
         .i_pend  (r_pend[w_addr]),
         .i_we    (w_run_we),
         .i_waddr (waddr),
         .i_wdata (wdata),
         .o_data  (rd_data[k*DATA_W +: DATA_W]),
         .o_pend  (rd_pending[k])
      );
   end

endmodule

// File: doc/pipelined_regfile.md
# pipelined_regfile

Parametrised integer register file for the pipelined core, succeeding the single-cycle register file. Adds a configurable number of combinational read ports, optional write-to-read bypass, and a per-register pending scoreboard for outstanding load writebacks. It also replaces the single-cycle bulk reset with a one-register-per-cycle clear sequencer. It sits between decode (read ports, claims) and writeback (write port).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers
- NREAD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- init_done  out  1  high once the clear sequence has finished; registered
- rd_addr  in  NREAD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NREAD*DATA_W  read data, same packing
- rd_pending  out  NREAD  per-port: addressed register has an outstanding claim
- we  in  1  write enable, active-high
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- claim_valid  in  1  mark register claim_addr as pending (load issued)
- claim_addr  in  ADDR_W  register to mark pending

## Operation
- States: CLEAR, RUN. rst forces CLEAR with clr_idx = 0 and all pending bits cleared, from any state on the next edge.
- CLEAR: each cycle, registers[clr_idx] <= 0 and clr_idx increments. When clr_idx == DEPTH-1, transition to RUN. we and claim_valid are ignored. All rd_data read 0 and all rd_pending read 0.
- RUN: a write with we=1 and waddr != 0 sets registers[waddr] <= wdata at the edge. Writes to address 0 are discarded.
- Register 0 reads 0 on every port at all times and is never pending.
- Read port k returns data selected in this order:
  - rd_addr_k == 0 gives 0.
  - Otherwise, BYPASS=1 with we && waddr == rd_addr_k gives wdata.
  - Otherwise, registers[rd_addr_k].
- Scoreboard: pending[claim_addr] is set at the edge when claim_valid=1 and claim_addr != 0. pending[waddr] is cleared at the edge when we=1.
- Simultaneous claim and write to the same address: set wins, so the pending bit ends at 1.
- rd_pending_k = pending[rd_addr_k], masked to 0 when rd_addr_k == 0.
- When BYPASS=1, rd_pending_k is additionally masked by a same-cycle write hit on that address, because the forwarded data is final.
- Multiple read ports may address the same register; each returns identical data.
- A claim on a register that is already pending leaves it pending; there is no counting.

## Timing
- Reset values: init_done = 0, all pending = 0, clr_idx = 0. rd_data and rd_pending are 0 while in CLEAR.
- Clear latency: rst deasserted at edge E0 means init_done = 1 from edge E0+DEPTH (32 cycles for ADDR_W=5).
- Reads are combinational: zero-cycle latency from rd_addr, we, waddr and wdata.
- A write is visible through storage on the cycle after its edge. With BYPASS=1 it is also visible in the same cycle.
- A claim is visible on rd_pending the cycle after its edge. A write's release is visible the cycle after its edge, or in the same cycle when BYPASS=1.
- rst asserted mid-CLEAR restarts at clr_idx = 0.
- rst asserted in RUN drops init_done on the next edge, discards any write in that cycle, and clears all pending bits.

## Structure
- Shared package holds DATA_W/ADDR_W defaults (replacing the DataBusBits/RegAddrBits macros), the state encoding (CLEAR=0, RUN=1), and the zero-register index constant.
- One sub-module, regfile_read_port: a single combinational read mux covering x0 masking, bypass and pending masking. It is instantiated NREAD times in a generate loop.
- Storage array, clear sequencer and scoreboard stay in the top module.

## Test plan
- Reset then idle, ADDR_W=5:
  - init_done stays 0 for 32 cycles, then 1.
  - Every address read during and after CLEAR returns 0.
- After init, write 0xDEADBEEF to r5. Same cycle, port0 reads r5:
  - BYPASS=1: returns 0xDEADBEEF.
  - BYPASS=0: returns 0.
  - Next cycle, both configurations return 0xDEADBEEF.
- Write 0x12345678 to r0, then read r0 on all ports -> 0. Claim r0 -> rd_pending stays 0.
- Claim r7, then read r7 next cycle -> rd_pending=1. Write r7 = 0x55:
  - BYPASS=1: pending clears the same cycle and data is 0x55.
  - Next cycle, pending = 0.
- Same cycle, claim r9 and write r9 = 0xAA -> next cycle r9 = 0xAA and rd_pending = 1.
- In RUN, write r3 = 0x1, then assert rst for 1 cycle mid-stream:
  - Pending bits clear.
  - init_done drops to 0 and returns after 32 cycles.
  - r3 reads 0.
  - Writes issued during CLEAR are ignored.
